// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
// Optional input synchroniser is selected with DEBOUNCE_BANK_SYNC_EN.
package debounce_pkg;

  localparam int DEFAULT_CHANNELS   = 4;
  localparam int DEFAULT_HIST_LEN   = 8;
  localparam int DEFAULT_PRESCALE_W = 16;
  localparam int MAX_HIST_LEN       = 64;

  // Constant with the low len bits set: the "stable high" history pattern.
  function automatic logic [MAX_HIST_LEN-1:0] hist_ones(input int len);
    logic [MAX_HIST_LEN-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_HIST_LEN; i++) begin
      v[i] = (i < len);
    end
    return v;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional 2-flop sync, shift history, hysteretic level,
// edge pulses and a sticky edge-pending flag (DEBOUNCE_BANK_SYNC_EN adds the sync).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int HIST_LEN = DEFAULT_HIST_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic button,
  input  logic ack,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam logic [HIST_LEN-1:0] HIST_ONES = HIST_LEN'(hist_ones(HIST_LEN));

  logic                sample;
  logic [HIST_LEN-1:0] hist;
  logic [HIST_LEN-1:0] hist_next;
  logic                rise_cond;
  logic                fall_cond;

`ifdef DEBOUNCE_BANK_SYNC_EN
  logic [1:0] sync_q;

  // The synchroniser runs every cycle so it never holds a stale metastable value.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], button};
  end

  assign sample = sync_q[1];
`else
  assign sample = button;
`endif

  assign hist_next = {hist[HIST_LEN-2:0], sample};
  assign rise_cond = strobe && (hist_next == HIST_ONES) && !debounced;
  assign fall_cond = strobe && (hist_next == '0) && debounced;

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist      <= '0;
      debounced <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (strobe) hist <= hist_next;
      // Mixed histories leave the level untouched, giving the hysteresis.
      if (rise_cond)      debounced <= 1'b1;
      else if (fall_cond) debounced <= 1'b0;
      rise    <= rise_cond;
      fall    <= fall_cond;
      // A new edge outranks a simultaneous acknowledge.
      pending <= (pending && !ack) || rise_cond || fall_cond;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer with shared strobe prescaler and interrupt summary.
// Define DEBOUNCE_BANK_SYNC_EN to add a 2-flop synchroniser on each input.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = DEFAULT_CHANNELS,
  parameter int HIST_LEN   = DEFAULT_HIST_LEN,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CHANNELS-1:0]   buttons,
  output logic [CHANNELS-1:0]   debounced,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   pending,
  input  logic [CHANNELS-1:0]   ack,
  output logic                  irq
);

  logic [PRESCALE_W-1:0] count;
  logic                  strobe;

  // Using >= lets a prescale lowered below the running count strobe at once.
  assign strobe = enable && (count >= prescale);

  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (strobe) count <= '0;
    else if (enable) count <= count + PRESCALE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |pending;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    debounce_channel #(
      .HIST_LEN (HIST_LEN)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .strobe    (strobe),
      .button    (buttons[i]),
      .ack       (ack[i]),
      .debounced (debounced[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pending   (pending[i])
    );
  end

endmodule
